// File: rtl/bru_predict_unit.sv
// Branch unit: 2-bit counter + tagged BTB predict at fetch, resolve/update at execute.
// Lookup is combinational; Redirect/RedirectPc register one cycle after resolve; no backpressure.
module bru_predict_unit #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      FetchPc,
  output logic                 PredTaken,
  output logic [XLEN-1:0]      PredPc,
  input  logic                 ExValid,
  input  logic [XLEN-1:0]      ExPc,
  input  logic [XLEN-1:0]      Source1,
  input  logic [XLEN-1:0]      Source2,
  input  logic [XLEN-1:0]      Immediate,
  input  logic [3:0]           BRUOperation,
  input  logic                 Jalr,
  input  logic                 ExPredTaken,
  input  logic [XLEN-1:0]      ExPredPc,
  output logic                 Redirect,
  output logic [XLEN-1:0]      RedirectPc,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [1:0]           cnt_q    [ENTRIES];
  logic [1:0]           cnt_d    [ENTRIES];
  logic [TW-1:0]        tag_q    [ENTRIES];
  logic [TW-1:0]        tag_d    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [XLEN-1:0]      target_d [ENTRIES];

  logic                 redirect_q, redirect_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  logic [IW-1:0]   f_idx, e_idx;
  logic [TW-1:0]   f_tag, e_tag;
  logic            f_hit;
  logic            is_br, taken, mispredict, upd;
  logic [XLEN-1:0] jalr_sum, act_target, act_next;

  // Low PC bits never index the table; ExPredTaken is informational only.
  logic unused_ok;
  assign unused_ok = ^{FetchPc[1:0], ExPc[1:0], ExPredTaken};

  assign f_idx = FetchPc[IW+1:2];
  assign f_tag = FetchPc[XLEN-1:IW+2];
  assign e_idx = ExPc[IW+1:2];
  assign e_tag = ExPc[XLEN-1:IW+2];

  assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTaken = f_hit && cnt_q[f_idx][1];
  assign PredPc    = PredTaken ? target_q[f_idx] : FetchPc + PC_STEP;

  always_comb begin
    taken = 1'b0;
    unique case (BRUOperation)
      4'd1:    taken = (Source1 == Source2);
      4'd2:    taken = (Source1 != Source2);
      4'd3:    taken = ($signed(Source1) <  $signed(Source2));
      4'd4:    taken = ($signed(Source1) >= $signed(Source2));
      4'd5:    taken = (Source1 <  Source2);
      4'd6:    taken = (Source1 >= Source2);
      4'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign is_br      = (BRUOperation != 4'd0) && !BRUOperation[3];
  assign jalr_sum   = Source1 + Immediate;
  assign act_target = Jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ExPc + Immediate;
  assign act_next   = taken ? act_target : ExPc + PC_STEP;
  assign upd        = ExValid && is_br;
  assign mispredict = upd && (act_next != ExPredPc);

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd) begin
      if (taken) begin
        if (cnt_q[e_idx] != 2'b11) cnt_d[e_idx] = cnt_q[e_idx] + 2'd1;
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = act_target;
      end else if (cnt_q[e_idx] != 2'b00) begin
        cnt_d[e_idx] = cnt_q[e_idx] - 2'd1;
      end
    end
  end

  assign redirect_d    = mispredict;
  assign redirect_pc_d = mispredict ? act_next : redirect_pc_q;
  assign mis_cnt_d     = mis_cnt_q + {{(CNT_WIDTH-1){1'b0}}, mispredict};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mis_cnt_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
    end else begin
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Tag/target are qualified by valid, so they need no reset; reset still blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign Redirect        = redirect_q;
  assign RedirectPc      = redirect_pc_q;
  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_bru_predict_unit.sv
module tb_bru_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] FetchPc;
  logic        PredTaken;
  logic [31:0] PredPc;
  logic        ExValid;
  logic [31:0] ExPc, Source1, Source2, Immediate, ExPredPc;
  logic [3:0]  BRUOperation;
  logic        Jalr, ExPredTaken;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic [31:0] MispredictCount;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] NOP = 4'd0, BEQ = 4'd1, BNE = 4'd2, BLT = 4'd3,
                         BGE = 4'd4, BLTU = 4'd5, BGEU = 4'd6, JMP = 4'd7;

  always #5 clk = ~clk;

  bru_predict_unit dut (
    .clk(clk), .reset(reset), .FetchPc(FetchPc), .PredTaken(PredTaken), .PredPc(PredPc),
    .ExValid(ExValid), .ExPc(ExPc), .Source1(Source1), .Source2(Source2),
    .Immediate(Immediate), .BRUOperation(BRUOperation), .Jalr(Jalr),
    .ExPredTaken(ExPredTaken), .ExPredPc(ExPredPc), .Redirect(Redirect),
    .RedirectPc(RedirectPc), .MispredictCount(MispredictCount)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic exp_t_, input logic [31:0] exp_pc);
    FetchPc = pc;
    #1;
    chk({name, ".taken"}, {31'd0, PredTaken}, {31'd0, exp_t_});
    chk({name, ".pc"}, PredPc, exp_pc);
  endtask

  // Drive one execute slot, queue its expected post-edge outputs, then check after the edge.
  task automatic resolve(input string name, input logic vld, input logic [3:0] op,
                         input logic jr, input logic [31:0] pc, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] imm,
                         input logic [31:0] ppc, input logic erd,
                         input logic [31:0] erpc, input logic [31:0] ecnt);
    exp_t e;
    ExValid = vld; BRUOperation = op; Jalr = jr; ExPc = pc;
    Source1 = s1; Source2 = s2; Immediate = imm; ExPredPc = ppc;
    ExPredTaken = (ppc != pc + 32'd4);
    e.name = name; e.rd = erd; e.rpc = erpc; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk); #1;
    ExValid = 1'b0; BRUOperation = NOP;
    e = sb.pop_front();
    chk({e.name, ".redirect"}, {31'd0, Redirect}, {31'd0, e.rd});
    chk({e.name, ".rpc"}, RedirectPc, e.rpc);
    chk({e.name, ".count"}, MispredictCount, e.cnt);
  endtask

  initial begin
    reset = 1'b1; FetchPc = '0; ExValid = 0; ExPc = '0; Source1 = '0; Source2 = '0;
    Immediate = '0; BRUOperation = NOP; Jalr = 0; ExPredTaken = 0; ExPredPc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst.redirect", {31'd0, Redirect}, 32'd0);
    chk("rst.rpc", RedirectPc, 32'd0);
    chk("rst.count", MispredictCount, 32'd0);
    look("rst.look", 32'h100, 1'b0, 32'h104);

    // BEQ taken, predicted fall-through: mispredict, entry 0 trained to 10
    resolve("beq1", 1, BEQ, 0, 32'h100, 5, 5, 32'h40, 32'h104, 1, 32'h140, 1);
    look("beq1.look", 32'h100, 1'b1, 32'h140);
    resolve("beq2", 1, BEQ, 0, 32'h100, 5, 5, 32'h40, 32'h140, 0, 32'h140, 1);
    resolve("beq3", 1, BEQ, 0, 32'h100, 5, 5, 32'h40, 32'h140, 0, 32'h140, 1);
    resolve("beq4", 1, BEQ, 0, 32'h100, 5, 5, 32'h40, 32'h140, 0, 32'h140, 1);
    resolve("beq_nt1", 1, BEQ, 0, 32'h100, 5, 6, 32'h40, 32'h140, 1, 32'h104, 2);
    look("sat11to10", 32'h100, 1'b1, 32'h140);
    resolve("beq_nt2", 1, BEQ, 0, 32'h100, 5, 6, 32'h40, 32'h140, 1, 32'h104, 3);
    look("cnt01", 32'h100, 1'b0, 32'h104);

    // JALR at 0x300 aliases entry 0 with a different tag
    resolve("jalr_ok", 1, JMP, 1, 32'h300, 32'h2001, 0, 32'h10, 32'h2010, 0, 32'h104, 3);
    look("alias.old", 32'h100, 1'b0, 32'h104);
    look("alias.new", 32'h300, 1'b1, 32'h2010);
    resolve("jalr_bad", 1, JMP, 1, 32'h300, 32'h2001, 0, 32'h10, 32'h2011, 1, 32'h2010, 4);

    // Signed vs unsigned, back-to-back at entry 1
    resolve("bltu", 1, BLTU, 0, 32'h404, 32'hFFFF_FFFF, 1, 32'h20, 32'h408, 0, 32'h2010, 4);
    resolve("blt", 1, BLT, 0, 32'h404, 32'hFFFF_FFFF, 1, 32'h20, 32'h408, 1, 32'h424, 5);
    look("blt.look", 32'h404, 1'b0, 32'h408);
    resolve("bge", 1, BGE, 0, 32'h404, 32'hFFFF_FFFF, 1, 32'h20, 32'h424, 1, 32'h408, 6);
    resolve("bgeu", 1, BGEU, 0, 32'h404, 32'hFFFF_FFFF, 1, 32'h20, 32'h408, 1, 32'h424, 7);
    resolve("bne", 1, BNE, 0, 32'h404, 3, 3, 32'h20, 32'h408, 0, 32'h424, 7);

    // Non-branches and invalid slots never redirect
    resolve("nop", 1, NOP, 0, 32'h404, 0, 0, 32'h20, 32'h0, 0, 32'h424, 7);
    resolve("op8", 1, 4'd8, 0, 32'h404, 0, 0, 32'h20, 32'h0, 0, 32'h424, 7);
    resolve("novld", 0, JMP, 0, 32'h404, 0, 0, 32'h20, 32'h0, 0, 32'h424, 7);
    look("nop.look", 32'h404, 1'b0, 32'h408);

    // Mispredict, then reset with a concurrent mispredict: pending redirect dropped
    resolve("pre_rst", 1, BEQ, 0, 32'h508, 1, 1, 32'h40, 32'h50C, 1, 32'h548, 8);
    reset = 1'b1;
    resolve("in_rst", 1, BEQ, 0, 32'h508, 1, 1, 32'h40, 32'h50C, 0, 32'h0, 0);
    reset = 1'b0;
    look("rst.clear0", 32'h300, 1'b0, 32'h304);
    look("rst.clear2", 32'h508, 1'b0, 32'h50C);

    // Lookup concurrent with update to same index sees the old entry
    FetchPc = 32'h508;
    ExValid = 1; BRUOperation = BEQ; Jalr = 0; ExPc = 32'h508; Source1 = 9; Source2 = 9;
    Immediate = 32'h40; ExPredPc = 32'h50C;
    #1;
    chk("rbw.old.taken", {31'd0, PredTaken}, 32'd0);
    chk("rbw.old.pc", PredPc, 32'h50C);
    resolve("rbw", 1, BEQ, 0, 32'h508, 9, 9, 32'h40, 32'h50C, 1, 32'h548, 1);
    look("rbw.new", 32'h508, 1'b1, 32'h548);
    resolve("idle", 0, NOP, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h548, 1);

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard.leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bru_predict_unit.md
Name: bru_predict_unit

Overview:
- Pipelined successor to the single-cycle branch unit. Resolves branches/jumps in execute and predicts them at fetch using a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB).
- Issues a registered redirect and flush request on mispredict. Keeps a mispredict counter for performance debug.
- Sits between the fetch stage (lookup port) and the execute stage (resolve/update port).

Parameters:
- XLEN, 32, data/PC width.
- ENTRIES, 64, number of predictor/BTB entries; power of two, 4..1024.
- CNT_WIDTH, 32, width of the mispredict counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- FetchPc  in  XLEN  PC being fetched.
- PredTaken  out  1  fetch prediction: taken.
- PredPc  out  XLEN  predicted next fetch PC.
- ExValid  in  1  execute slot holds a valid instruction.
- ExPc  in  XLEN  PC of the executing instruction.
- Source1, Source2  in  XLEN  comparison operands.
- Immediate  in  XLEN  branch/jump offset.
- BRUOperation  in  4  encoding: 0 NOP, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 JMP; others are treated as NOP.
- Jalr  in  1  register-relative jump.
- ExPredTaken  in  1  prediction carried down the pipe with the instruction.
- ExPredPc  in  XLEN  predicted next PC carried down the pipe.
- Redirect  out  1  registered: mispredict, flush younger instructions.
- RedirectPc  out  XLEN  registered: correct next PC.
- MispredictCount  out  CNT_WIDTH  number of mispredicts since reset.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Index and tag: idx = Pc[log2(ENTRIES)+1:2]; tag = Pc[XLEN-1:log2(ENTRIES)+2].
- Lookup (combinational, no latency):
  - hit = valid[idx] && tag match.
  - PredTaken = hit && cnt[idx][1].
  - PredPc = PredTaken ? target[idx] : FetchPc+4.
- Resolution (combinational from execute inputs):
  - Comparisons: signed for LT/GE, unsigned for LTU/GEU. JMP is always taken.
  - Actual target = Jalr ? (Source1+Immediate) with bit0 cleared : ExPc+Immediate. All sums are modulo 2^XLEN.
  - ActualNext = taken ? target : ExPc+4.
  - Mispredict = ExValid && op!=NOP && (ActualNext != ExPredPc).
  - A NOP with ExValid never mispredicts and never updates state.
- Latency: Redirect and RedirectPc register at the clock edge after the resolving cycle, so they are high for exactly one cycle per mispredict. RedirectPc holds its last value while Redirect=0.
- Update at the same edge, when ExValid && op!=NOP:
  - cnt[idx(ExPc)] saturating: +1 if taken, -1 if not; 11 and 00 saturate.
  - If taken: write tag, target, valid=1.
  - If not taken: BTB entry unchanged.
- Read-before-write: a lookup in the same cycle as an update to the same index sees the old entry.
- MispredictCount increments by 1 per mispredict and wraps at 2^CNT_WIDTH.
- Reset:
  - All valid bits clear; all counters = 01 (weakly not-taken).
  - Redirect=0, RedirectPc=0, MispredictCount=0.
  - Reset takes priority over a concurrent resolve: no update and no redirect for that cycle.
  - A redirect pending from the cycle before reset is dropped.
- Back-to-back resolves every cycle are supported. Each updates independently; consecutive updates to the same index accumulate.
- Aliasing: on tag mismatch, PredTaken=0 even if the counter is taken. A taken update overwrites the tag.

Test Plan:
- Reset, then FetchPc=0x100 -> PredTaken=0, PredPc=0x104. Redirect=0, MispredictCount=0.
- BEQ at 0x100, Source1=Source2=5, Immediate=0x40, ExPredPc=0x104 -> next cycle Redirect=1, RedirectPc=0x140, MispredictCount=1. Then FetchPc=0x100 -> PredTaken=1 (counter 10), PredPc=0x140.
- Same BEQ resolved taken 3 more times -> counter saturates at 11. Then 1 not-taken -> 10, still predicted taken. A second not-taken -> 01, predicted not-taken.
- JALR with Source1=0x2001, Immediate=0x10, ExPredPc=0x2010 -> no redirect (target 0x2010, bit0 cleared). Same with ExPredPc=0x2011 -> Redirect=1, RedirectPc=0x2010.
- BLTU vs BLT with Source1=0xFFFFFFFF, Source2=1 -> BLTU not taken, BLT taken. With ExPredPc=ExPc+4, Redirect fires only for BLT.
- Mispredict resolving in the cycle reset asserts -> Redirect stays 0, the table entry stays invalid, MispredictCount=0. Lookup and update to the same index in one cycle -> the lookup returns the old prediction, and the new prediction appears the following cycle.
